// File: rtl/flash_write_sched.sv
// Multi-page flash write scheduler: splits a byte transfer on 256 B page boundaries and issues
// one page-program request per chunk. Define FLASH_SCHED_ERASE_EN to erase each new 4 KB sector.
module flash_write_sched #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned GAP_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              system_clk,
    input  logic              system_reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  total_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              pp_key,
    output logic [ADDR_W-1:0] pp_addr,
    output logic [7:0]        pp_num,
    input  logic              pp_done,
    output logic              se_key,
    output logic [ADDR_W-1:0] se_addr,
    input  logic              se_done
);

    localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StPpIssue,
        StPpWait,
        StGap,
        StFinish
`ifdef FLASH_SCHED_ERASE_EN
        ,
        StSeIssue,
        StSeWait
`endif
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cur_q;
    logic [LEN_W-1:0]  rem_q;
    logic [GapW-1:0]   gap_q;
    logic [WaitW-1:0]  wait_q;

    // Chunk size minus one: bytes left in the current page, capped by the remaining length.
    function automatic logic [7:0] chunk_num(input logic [7:0] offs, input logic [LEN_W-1:0] len);
        logic [8:0] room;
        logic [8:0] chunk;
        room = 9'd256 - {1'b0, offs};
        if (len < LEN_W'(room)) begin
            chunk = len[8:0];
        end else begin
            chunk = room;
        end
        chunk = chunk - 9'd1;
        return chunk[7:0];
    endfunction

    logic [7:0]        num_cur;
    logic [ADDR_W-1:0] cur_next;
    logic [LEN_W-1:0]  rem_next;

    assign num_cur  = chunk_num(cur_q[7:0], rem_q);
    // pp_num holds the in-flight chunk size minus one.
    assign cur_next = cur_q + ADDR_W'(pp_num) + ADDR_W'(1);
    assign rem_next = rem_q - LEN_W'(pp_num) - LEN_W'(1);

`ifndef FLASH_SCHED_ERASE_EN
    logic [7:0] num_start;
    assign num_start = chunk_num(start_addr[7:0], total_len);
    assign se_key  = 1'b0;
    assign se_addr = '0;
    logic unused_se_done;
    assign unused_se_done = se_done;
`endif

    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= StIdle;
            cur_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            wait_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            pp_key  <= 1'b0;
            pp_addr <= '0;
            pp_num  <= '0;
`ifdef FLASH_SCHED_ERASE_EN
            se_key  <= 1'b0;
            se_addr <= '0;
`endif
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            pp_key <= 1'b0;
`ifdef FLASH_SCHED_ERASE_EN
            se_key <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cur_q <= start_addr;
                        rem_q <= total_len;
                        busy  <= 1'b1;
                        if (total_len == '0) begin
                            state_q <= StFinish;
                        end else begin
`ifdef FLASH_SCHED_ERASE_EN
                            state_q <= StSeIssue;
                            se_key  <= 1'b1;
                            se_addr <= {start_addr[ADDR_W-1:12], 12'h000};
`else
                            state_q <= StPpIssue;
                            pp_key  <= 1'b1;
                            pp_addr <= start_addr;
                            pp_num  <= num_start;
`endif
                        end
                    end
                end
                StPpIssue: begin
                    state_q <= StPpWait;
                    wait_q  <= '0;
                end
                StPpWait: begin
                    // Completion takes priority over a timeout expiring in the same cycle.
                    if (pp_done) begin
                        cur_q <= cur_next;
                        rem_q <= rem_next;
                        gap_q <= '0;
                        if (rem_next == '0) begin
                            state_q <= StFinish;
                        end else begin
                            state_q <= StGap;
                        end
                    end else if (wait_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StGap: begin
                    if (gap_q == GapW'(GAP_CYCLES - 1)) begin
`ifdef FLASH_SCHED_ERASE_EN
                        if (cur_q[11:0] == 12'h000) begin
                            state_q <= StSeIssue;
                            se_key  <= 1'b1;
                            se_addr <= {cur_q[ADDR_W-1:12], 12'h000};
                        end else begin
                            state_q <= StPpIssue;
                            pp_key  <= 1'b1;
                            pp_addr <= cur_q;
                            pp_num  <= num_cur;
                        end
`else
                        state_q <= StPpIssue;
                        pp_key  <= 1'b1;
                        pp_addr <= cur_q;
                        pp_num  <= num_cur;
`endif
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
`ifdef FLASH_SCHED_ERASE_EN
                StSeIssue: begin
                    state_q <= StSeWait;
                    wait_q  <= '0;
                end
                StSeWait: begin
                    if (se_done) begin
                        state_q <= StPpIssue;
                        pp_key  <= 1'b1;
                        pp_addr <= cur_q;
                        pp_num  <= num_cur;
                    end else if (wait_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                        done    <= 1'b1;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
`endif
                StFinish: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
